// File: rtl/dmem_lsu_ctrl.sv
// Load/store unit between core and a word-wide data memory: byte/half/word access, sign/zero extend, RMW sub-word stores.
// Latency: load and word store 2 cycles, byte/half store 3 cycles, errors 1 cycle (acceptance edge to response pulse).
// Backpressure: one request in flight; o_req_ready is high only in IDLE, and the response pulse cannot be stalled.
// Optional macro LSU_MISALIGN_CHK_EN turns misaligned half/word accesses into error responses.
module dmem_lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_ld,
    output logic                  o_mem_st,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic                  uns;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state_q, state_d;
    req_t                  req_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] word_q;

    logic                  accept;
    logic                  req_err;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;

    assign accept = i_req_valid && o_req_ready;

    always_comb begin
        req_err = (i_req_size == 2'b11);
`ifdef LSU_MISALIGN_CHK_EN
        if (i_req_size == 2'b01 && i_req_addr[0])
            req_err = 1'b1;
        if (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Lane selection uses the latched address; misaligned low bits are simply dropped.
    always_comb begin
        lane_byte = 8'h00;
        case (req_q.addr[1:0])
            2'b00:   lane_byte = i_mem_rdata[7:0];
            2'b01:   lane_byte = i_mem_rdata[15:8];
            2'b10:   lane_byte = i_mem_rdata[23:16];
            default: lane_byte = i_mem_rdata[31:24];
        endcase
        lane_half = req_q.addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (req_q.size)
            2'b00:   load_ext = {{(DATA_WIDTH-8){~req_q.uns & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{(DATA_WIDTH-16){~req_q.uns & lane_half[15]}}, lane_half};
            default: load_ext = i_mem_rdata;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (req_q.size)
            2'b00: begin
                case (req_q.addr[1:0])
                    2'b00:   merged[7:0]   = req_q.wdata[7:0];
                    2'b01:   merged[15:8]  = req_q.wdata[7:0];
                    2'b10:   merged[23:16] = req_q.wdata[7:0];
                    default: merged[31:24] = req_q.wdata[7:0];
                endcase
            end
            2'b01: begin
                if (req_q.addr[1])
                    merged[31:16] = req_q.wdata[15:0];
                else
                    merged[15:0] = req_q.wdata[15:0];
            end
            default: merged = req_q.wdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!i_req_we)
                        state_d = LOAD;
                    else if (i_req_size == 2'b10)
                        state_d = STORE;
                    else
                        state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            STORE:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q.we    <= i_req_we;
                req_q.size  <= i_req_size;
                req_q.uns   <= i_req_unsigned;
                req_q.addr  <= i_req_addr;
                req_q.wdata <= i_req_wdata;
                err_q       <= req_err;
                rdata_q     <= '0;
            end
            if (state_q == LOAD)
                rdata_q <= load_ext;
            if (state_q == RMW_RD)
                word_q <= i_mem_rdata;
        end
    end

    always_comb begin
        o_req_ready = (state_q == IDLE) && !i_rst;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_err   = 1'b0;
        o_mem_ld    = 1'b0;
        o_mem_st    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            LOAD, RMW_RD: begin
                o_mem_ld   = 1'b1;
                o_mem_addr = {req_q.addr[ADDR_WIDTH-1:2], 2'b00};
            end
            STORE, RMW_WR: begin
                o_mem_st    = 1'b1;
                o_mem_addr  = {req_q.addr[ADDR_WIDTH-1:2], 2'b00};
                o_mem_wdata = merged;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_rdata = rdata_q;
                o_rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed scenarios then random traffic against a shift/mask memory model.
// Honours LSU_MISALIGN_CHK_EN when computing expected error responses.
module tb_dmem_lsu_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_mem_ld;
    logic        o_mem_st;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    dmem_lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_ld(o_mem_ld), .o_mem_st(o_mem_st), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;
    int ld_cnt = 0, st_cnt = 0, both_cnt = 0, bad_addr_cnt = 0, junk_cnt = 0, rsp_cnt = 0;
    int n_cmp = 0, n_bad = 0;

    assign i_mem_rdata = o_mem_ld ? mem[o_mem_addr[7:2]] : 32'hA5A5_5A5A;

    always @(posedge i_clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (o_mem_st)
            mem[o_mem_addr[7:2]] <= o_mem_wdata;
        if (o_mem_ld) ld_cnt <= ld_cnt + 1;
        if (o_mem_st) st_cnt <= st_cnt + 1;
        if (o_mem_ld && o_mem_st) both_cnt <= both_cnt + 1;
        if ((o_mem_ld || o_mem_st) && o_mem_addr[1:0] != 2'b00) bad_addr_cnt <= bad_addr_cnt + 1;
    end

    always @(negedge i_clk) begin
        if (!o_rsp_valid && (o_rsp_rdata != 32'h0 || o_rsp_err)) junk_cnt <= junk_cnt + 1;
        if (o_rsp_valid && (o_mem_ld || o_mem_st)) junk_cnt <= junk_cnt + 1;
        if (o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge i_clk);
        pl_en  = 1'b1;
        pl_idx = idx[5:0];
        pl_val = val;
        ref_mem[idx] = val;
        @(posedge i_clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] w, sh, mask, exp_rd, v;
        logic        exp_err;
        int          idx, exp_lat, exp_ld, exp_st, lat, ld0, st0;
        idx = int'(addr[7:2]);
        w = ref_mem[idx];
        exp_err = (size == 2'b11);
`ifdef LSU_MISALIGN_CHK_EN
        if (size == 2'b01 && addr[0]) exp_err = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
        sh   = (size == 2'b00) ? {30'd0, addr[1:0]} * 8 : (size == 2'b01) ? {31'd0, addr[1]} * 16 : 32'd0;
        mask = (size == 2'b00) ? 32'hFF : (size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        exp_rd = 32'h0;
        if (!exp_err && !we) begin
            v = (w >> sh) & mask;
            if (!uns && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
            if (!uns && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            exp_rd = v;
        end
        if (!exp_err && we)
            ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        exp_lat = exp_err ? 1 : (!we || size == 2'b10) ? 2 : 3;
        exp_ld  = exp_err ? 0 : (!we) ? 1 : (size == 2'b10) ? 0 : 1;
        exp_st  = (!exp_err && we) ? 1 : 0;

        @(negedge i_clk);
        chk("ready_idle", {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1; i_req_we = we; i_req_size = size;
        i_req_unsigned = uns; i_req_addr = addr; i_req_wdata = wdata;
        ld0 = ld_cnt; st0 = st_cnt;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            lat++;
            if (o_rsp_valid) break;
            chk("ready_busy", {31'd0, o_req_ready}, 32'd0);
        end
        chk("rsp_seen", {31'd0, o_rsp_valid}, 32'd1);
        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, exp_err});
        chk("rsp_rdata", o_rsp_rdata, exp_rd);
        chk("ready_in_resp", {31'd0, o_req_ready}, 32'd0);
        @(negedge i_clk);
        chk("rsp_one_pulse", {31'd0, o_rsp_valid}, 32'd0);
        chk("ready_after", {31'd0, o_req_ready}, 32'd1);
        chk("ld_strobes", ld_cnt - ld0, exp_ld);
        chk("st_strobes", st_cnt - st0, exp_st);
        chk("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int st0, rsp0;
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'b00;
        i_req_unsigned = 1'b0; i_req_addr = 32'h0; i_req_wdata = 32'h0; pl_en = 1'b0;
        pl_idx = 6'd0; pl_val = 32'h0;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", {31'd0, o_req_ready}, 32'd0);
        chk("rst_outs", {28'd0, o_rsp_valid, o_rsp_err, o_mem_ld, o_mem_st}, 32'd0);
        chk("rst_data", o_rsp_rdata | o_mem_addr | o_mem_wdata, 32'd0);
        i_rst = 1'b0;
        #1 chk("rel_ready", {31'd0, o_req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) set_word(i, $urandom);

        // Directed scenarios
        set_word(16, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_00AB);
        chk("byte_rmw_val", mem[16], 32'h1122_AB44);
        set_word(16, 32'h8001_7FFF);
        do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
        chk("word_store_val", mem[32], 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h43, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'h44, 32'h1234_5678);
        do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h46, 32'h0000_CAFE);

        // Reset while the RMW read is in flight
        set_word(16, 32'h1122_3344);
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b00;
        i_req_addr = 32'h41; i_req_wdata = 32'hAB;
        st0 = st_cnt;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        rsp0 = rsp_cnt;
        chk("rmw_rd_ld", {31'd0, o_mem_ld}, 32'd1);
        i_rst = 1'b1;
        #1 chk("midrst_outs", {28'd0, o_rsp_valid, o_req_ready, o_mem_ld, o_mem_st}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1 chk("midrst_ready", {31'd0, o_req_ready}, 32'd1);
        repeat (3) @(negedge i_clk);
        chk("midrst_no_st", st_cnt - st0, 32'd0);
        chk("midrst_no_rsp", rsp_cnt - rsp0, 32'd0);
        chk("midrst_mem", mem[16], 32'h1122_3344);

        // Random traffic
        for (int i = 0; i < 300; i++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), $urandom);

        chk("ld_st_overlap", both_cnt, 32'd0);
        chk("mem_addr_align", bad_addr_cnt, 32'd0);
        chk("rsp_idle_zero", junk_cnt, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
